// File: rtl/hdlc_chk_pkg.sv
// Shared definitions for the HDLC protocol checker: check IDs, flag pattern,
// Tx abort FSM states and a violation popcount helper.
package hdlc_chk_pkg;

    localparam int NUM_CHECKS = 5;
    localparam int POP_W      = $clog2(NUM_CHECKS + 1);

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;

    typedef enum logic [2:0] {
        CHK_FLAG      = 3'd0,
        CHK_ABORT_SIG = 3'd1,
        CHK_EOF       = 3'd2,
        CHK_OVF       = 3'd3,
        CHK_TX_ABORT  = 3'd4
    } checkId_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } txAbortState_e;

    function automatic logic [POP_W-1:0] popCount(input logic [NUM_CHECKS-1:0] bits);
        logic [POP_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            total = total + POP_W'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/hdlc_chk_satcnt.sv
// Saturating accumulator: adds Inc every cycle, sticks at all-ones, Clr restarts
// the sum from zero while still taking the same-cycle increment.
module hdlc_chk_satcnt #(
    parameter int WIDTH = 16,
    parameter int INC_W = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic [INC_W-1:0] Inc,
    output logic [WIDTH-1:0] Count
);

    localparam int SUM_W = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << WIDTH) - SUM_W'(1);

    function automatic logic [WIDTH-1:0] satAdd(input logic [WIDTH-1:0] base,
                                                input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > SAT_MAX) begin
            return {WIDTH{1'b1}};
        end
        return sum[WIDTH-1:0];
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Count <= '0;
        end else begin
            Count <= satAdd(Clr ? {WIDTH{1'b0}} : Count, Inc);
        end
    end

endmodule

// File: rtl/hdlc_protocol_checker.sv
// HDLC protocol checker: watches Rx/Tx control strobes against their stimulus and
// reports per-check violations as pulses, sticky flags and a saturating count.
module hdlc_protocol_checker
    import hdlc_chk_pkg::*;
#(
    parameter int FLAG_LAT  = 2,
    parameter int MAX_BYTES = 128,
    parameter int ABORT_WIN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Rx,
    input  logic                  Rx_FlagDetect,
    input  logic                  Rx_AbortDetect,
    input  logic                  Rx_AbortSignal,
    input  logic                  Rx_ValidFrame,
    input  logic                  Rx_EoF,
    input  logic                  Rx_NewByte,
    input  logic                  Rx_Overflow,
    input  logic                  Tx_AbortFrame,
    input  logic                  Tx_ValidFrame,
    input  logic                  Tx_AbortedTrans,
    input  logic [NUM_CHECKS-1:0] CheckEn,
    input  logic                  ErrClr,
    output logic [NUM_CHECKS-1:0] ErrPulse,
    output logic [NUM_CHECKS-1:0] ErrSticky,
    output logic [CNT_W-1:0]      ErrCnt
);

    localparam int BC_W  = $clog2(MAX_BYTES + 1);
    localparam int TMR_W = $clog2(ABORT_WIN + 1);

    logic [6:0]            rxHist;
    logic                  flagMatch;
    logic [FLAG_LAT-1:0]   flagPend;
    logic                  abortArm_p1;
    logic                  prevValid;
    logic                  eofArm_p1;
    logic [BC_W-1:0]       byteCnt;
    logic                  byteClr;
    logic                  ovfArm_p1;
    txAbortState_e         txState;
    logic [TMR_W-1:0]      txTimer;
    logic                  txExpire;
    logic [NUM_CHECKS-1:0] violation;
    logic [NUM_CHECKS-1:0] pulseNext;
    logic [POP_W-1:0]      pulseCount;

    // Window is oldest bit in the MSB, current Rx in the LSB.
    assign flagMatch = ({rxHist, Rx} == FLAG_PATTERN);
    assign byteClr   = Rx_FlagDetect && !Rx_ValidFrame;
    assign txExpire  = (txState == WAIT) && !Tx_AbortedTrans && (txTimer <= TMR_W'(1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxHist      <= 7'h7F;
            flagPend    <= '0;
            abortArm_p1 <= 1'b0;
            prevValid   <= 1'b0;
            eofArm_p1   <= 1'b0;
            byteCnt     <= '0;
            ovfArm_p1   <= 1'b0;
        end else begin
            rxHist      <= {rxHist[5:0], Rx};
            flagPend    <= (flagPend << 1) | FLAG_LAT'(flagMatch);
            abortArm_p1 <= Rx_AbortDetect && Rx_ValidFrame;
            prevValid   <= Rx_ValidFrame;
            eofArm_p1   <= prevValid && !Rx_ValidFrame;
            // Only the step onto MAX_BYTES arms the overflow check.
            ovfArm_p1   <= !byteClr && Rx_NewByte && (byteCnt == BC_W'(MAX_BYTES - 1));
            if (byteClr) begin
                byteCnt <= '0;
            end else if (Rx_NewByte && (byteCnt != BC_W'(MAX_BYTES))) begin
                byteCnt <= byteCnt + BC_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            txState <= IDLE;
            txTimer <= '0;
        end else begin
            case (txState)
                IDLE: begin
                    if (Tx_AbortFrame && Tx_ValidFrame) begin
                        txState <= WAIT;
                        txTimer <= TMR_W'(ABORT_WIN);
                    end
                end
                WAIT: begin
                    // Acknowledge on the expiry cycle still wins over the timeout.
                    if (Tx_AbortedTrans) begin
                        txState <= DONE;
                        txTimer <= '0;
                    end else if (txTimer <= TMR_W'(1)) begin
                        txState <= IDLE;
                        txTimer <= '0;
                    end else begin
                        txTimer <= txTimer - TMR_W'(1);
                    end
                end
                DONE: begin
                    if (!Tx_AbortFrame) begin
                        txState <= IDLE;
                    end
                end
                default: begin
                    txState <= IDLE;
                    txTimer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        violation                = '0;
        violation[CHK_FLAG]      = flagPend[FLAG_LAT-1] && !Rx_FlagDetect;
        violation[CHK_ABORT_SIG] = abortArm_p1 && !Rx_AbortSignal;
        violation[CHK_EOF]       = eofArm_p1 && !Rx_EoF;
        violation[CHK_OVF]       = ovfArm_p1 && !Rx_Overflow;
        violation[CHK_TX_ABORT]  = txExpire;
        pulseNext                = violation & CheckEn;
    end

    assign pulseCount = popCount(pulseNext);

    // Report stage: pulse, sticky and count all reflect the same violation set.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ErrPulse  <= '0;
            ErrSticky <= '0;
        end else begin
            ErrPulse  <= pulseNext;
            ErrSticky <= (ErrClr ? '0 : ErrSticky) | pulseNext;
        end
    end

    hdlc_chk_satcnt #(
        .WIDTH (CNT_W),
        .INC_W (POP_W)
    ) uErrCnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (ErrClr),
        .Inc   (pulseCount),
        .Count (ErrCnt)
    );

endmodule

// File: tb/tb_hdlc_protocol_checker.sv
// Bench for hdlc_protocol_checker: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the check rules.
module tb_hdlc_protocol_checker;

    localparam int FLAG_LAT  = 2;
    localparam int MAX_BYTES = 128;
    localparam int ABORT_WIN = 16;
    localparam int MAXC      = 8192;

    logic       Clk;
    logic       Rst;
    logic       Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame;
    logic       Rx_EoF, Rx_NewByte, Rx_Overflow;
    logic       Tx_AbortFrame, Tx_ValidFrame, Tx_AbortedTrans;
    logic [4:0] CheckEn;
    logic       ErrClr;
    logic [4:0] ErrPulse, ErrSticky, ErrPulseS, ErrStickyS;
    logic [15:0] ErrCnt;
    logic [1:0]  ErrCntS;

    int checks = 0;
    int errors = 0;

    hdlc_protocol_checker #(
        .FLAG_LAT(FLAG_LAT), .MAX_BYTES(MAX_BYTES), .ABORT_WIN(ABORT_WIN), .CNT_W(16)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_EoF(Rx_EoF), .Rx_NewByte(Rx_NewByte),
        .Rx_Overflow(Rx_Overflow), .Tx_AbortFrame(Tx_AbortFrame),
        .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans),
        .CheckEn(CheckEn), .ErrClr(ErrClr),
        .ErrPulse(ErrPulse), .ErrSticky(ErrSticky), .ErrCnt(ErrCnt)
    );

    hdlc_protocol_checker #(
        .FLAG_LAT(FLAG_LAT), .MAX_BYTES(MAX_BYTES), .ABORT_WIN(ABORT_WIN), .CNT_W(2)
    ) dutSmall (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_EoF(Rx_EoF), .Rx_NewByte(Rx_NewByte),
        .Rx_Overflow(Rx_Overflow), .Tx_AbortFrame(Tx_AbortFrame),
        .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans),
        .CheckEn(CheckEn), .ErrClr(ErrClr),
        .ErrPulse(ErrPulseS), .ErrSticky(ErrStickyS), .ErrCnt(ErrCntS)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: per-edge input history since the last reset release.
    bit   rxA[MAXC];
    bit   avA[MAXC];
    bit   vfA[MAXC];
    int   n = 0;
    int   mBytes = 0;
    bit   mOvfDue = 0;
    int   mTxPhase = 0;
    int   mTxStart = 0;
    logic [4:0] mV = '0;
    bit   mMatch;
    bit   mBit;
    int   mIdx;
    logic [4:0] expPulse = '0;
    logic [4:0] expSticky = '0;
    int   expCnt = 0;
    int   expCntS = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            n = 0; mBytes = 0; mOvfDue = 0; mTxPhase = 0; mTxStart = 0;
            expPulse = '0; expSticky = '0; expCnt = 0; expCntS = 0;
        end else begin
            rxA[n] = Rx;
            avA[n] = Rx_AbortDetect && Rx_ValidFrame;
            vfA[n] = Rx_ValidFrame;
            mV = '0;
            if (n >= FLAG_LAT) begin
                mMatch = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    mIdx = n - FLAG_LAT - 7 + k;
                    mBit = (mIdx < 0) ? 1'b1 : rxA[mIdx];
                    if (mBit != ((k == 0 || k == 7) ? 1'b0 : 1'b1)) mMatch = 1'b0;
                end
                if (mMatch && !Rx_FlagDetect) mV[0] = 1'b1;
            end
            if (n >= 1 && avA[n-1] && !Rx_AbortSignal) mV[1] = 1'b1;
            if (n >= 2 && vfA[n-2] && !vfA[n-1] && !Rx_EoF) mV[2] = 1'b1;
            if (mOvfDue && !Rx_Overflow) mV[3] = 1'b1;
            if (Rx_FlagDetect && !Rx_ValidFrame) begin
                mBytes = 0; mOvfDue = 0;
            end else if (Rx_NewByte && mBytes < MAX_BYTES) begin
                mBytes++; mOvfDue = (mBytes == MAX_BYTES);
            end else begin
                mOvfDue = 0;
            end
            case (mTxPhase)
                0: if (Tx_AbortFrame && Tx_ValidFrame) begin mTxPhase = 1; mTxStart = n; end
                1: if (Tx_AbortedTrans) mTxPhase = 2;
                   else if (n - mTxStart >= ABORT_WIN) begin mV[4] = 1'b1; mTxPhase = 0; end
                2: if (!Tx_AbortFrame) mTxPhase = 0;
                default: mTxPhase = 0;
            endcase
            expPulse = mV & CheckEn;
            if (ErrClr) begin expSticky = '0; expCnt = 0; expCntS = 0; end
            expSticky = expSticky | expPulse;
            expCnt  = expCnt + $countones(expPulse);
            if (expCnt > 65535) expCnt = 65535;
            expCntS = expCntS + $countones(expPulse);
            if (expCntS > 3) expCntS = 3;
            if (n < MAXC - 1) n++;
        end
    end

    always @(negedge Clk) begin
        if (Rst === 1'b0) begin
            chk("model_pulse",   32'(ErrPulse),   32'(expPulse));
            chk("model_sticky",  32'(ErrSticky),  32'(expSticky));
            chk("model_cnt",     32'(ErrCnt),     32'(expCnt));
            chk("model_pulse_s", 32'(ErrPulseS),  32'(expPulse));
            chk("model_cnt_s",   32'(ErrCntS),    32'(expCntS));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet();
        Rx = 1'b1; Rx_FlagDetect = 0; Rx_AbortDetect = 0; Rx_AbortSignal = 0;
        Rx_ValidFrame = 0; Rx_EoF = 0; Rx_NewByte = 0; Rx_Overflow = 0;
        Tx_AbortFrame = 0; Tx_ValidFrame = 0; Tx_AbortedTrans = 0;
        CheckEn = 5'h1F; ErrClr = 0;
    endtask

    task automatic sendFlag();
        Rx = 1'b0; step();
        repeat (6) begin Rx = 1'b1; step(); end
        Rx = 1'b0; step();
    endtask

    bit fdPlan[4096];

    initial begin
        int n3, n4, nz, injLeft, phase;
        Rst = 1'b1;
        quiet();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_pulse",  32'(ErrPulse),  0);
        chk("rst_sticky", 32'(ErrSticky), 0);
        chk("rst_cnt",    32'(ErrCnt),    0);
        #2 Rst = 1'b0;
        step();

        // Flag detected on time
        ErrClr = 1; step(); ErrClr = 0;
        sendFlag();
        Rx = 1'b1; step();
        Rx_FlagDetect = 1; step();
        chk("flag_on_time", 32'(ErrPulse), 0);
        Rx_FlagDetect = 0; step();

        // Flag detected one cycle late
        sendFlag();
        Rx = 1'b1; step(); step();
        chk("flag_late_pulse", 32'(ErrPulse), 1);
        chk("flag_late_cnt",   32'(ErrCnt),   1);
        Rx_FlagDetect = 1; step();
        chk("flag_pulse_once", 32'(ErrPulse), 0);
        Rx_FlagDetect = 0; step();

        // Abort detected without abort signal
        ErrClr = 1; Rx_AbortDetect = 1; Rx_ValidFrame = 1; step();
        ErrClr = 0; Rx_AbortDetect = 0; step();
        chk("abort_sig_pulse",  32'(ErrPulse),  2);
        chk("abort_sig_sticky", 32'(ErrSticky), 2);
        Rx_ValidFrame = 0; step();
        Rx_EoF = 1; step();
        chk("eof_ok", 32'(ErrPulse), 0);
        Rx_EoF = 0; step();

        // Byte overflow
        Rx_FlagDetect = 1; step(); Rx_FlagDetect = 0;
        n3 = 0;
        repeat (MAX_BYTES) begin Rx_NewByte = 1; step(); if (ErrPulse[3]) n3++; end
        Rx_NewByte = 0; Rx_Overflow = 1; step(); if (ErrPulse[3]) n3++;
        Rx_Overflow = 0; step(); if (ErrPulse[3]) n3++;
        chk("ovf_128_ok", 32'(n3), 0);
        Rx_FlagDetect = 1; step(); Rx_FlagDetect = 0;
        n3 = 0;
        repeat (200) begin Rx_NewByte = 1; step(); if (ErrPulse[3]) n3++; end
        Rx_NewByte = 0;
        repeat (3) begin step(); if (ErrPulse[3]) n3++; end
        chk("ovf_200_once", 32'(n3), 1);

        // Tx abort acknowledged at the last allowed cycle
        Tx_AbortFrame = 1; Tx_ValidFrame = 1; step(); Tx_ValidFrame = 0;
        n4 = 0;
        for (int k = 1; k <= 20; k++) begin
            Tx_AbortedTrans = (k == 16); step();
            if (ErrPulse[4]) n4++;
        end
        Tx_AbortedTrans = 0; Tx_AbortFrame = 0; step();
        chk("txabort_16_pass", 32'(n4), 0);

        // Tx abort acknowledged one cycle too late
        Tx_AbortFrame = 1; Tx_ValidFrame = 1; step(); Tx_ValidFrame = 0;
        n4 = 0;
        for (int k = 1; k <= 17; k++) begin
            Tx_AbortedTrans = (k == 17); step();
            if (k == 16) chk("txabort_17_fail", 32'(ErrPulse[4]), 1);
            else if (ErrPulse[4]) n4++;
        end
        Tx_AbortedTrans = 0; Tx_AbortFrame = 0; step();
        chk("txabort_single_pulse", 32'(n4), 0);

        // Counter saturation and clear with coincident violation
        ErrClr = 1; step(); ErrClr = 0;
        Rx_ValidFrame = 1; Rx_AbortDetect = 1;
        repeat (5) step();
        Rx_AbortDetect = 0; step();
        chk("satcnt_small", 32'(ErrCntS), 3);
        chk("satcnt_wide",  32'(ErrCnt),  5);
        Rx_AbortDetect = 1; step();
        Rx_AbortDetect = 0; ErrClr = 1; step(); ErrClr = 0;
        chk("clr_hit_small",  32'(ErrCntS),   1);
        chk("clr_hit_wide",   32'(ErrCnt),    1);
        chk("clr_hit_sticky", 32'(ErrSticky), 2);
        Rx_ValidFrame = 0; step();
        Rx_EoF = 1; step(); Rx_EoF = 0;

        // Reset in the middle of a flag
        Rx = 1'b0; step();
        repeat (4) begin Rx = 1'b1; step(); end
        #2 Rst = 1'b1;
        #1;
        chk("midrst_pulse",  32'(ErrPulse),  0);
        chk("midrst_sticky", 32'(ErrSticky), 0);
        chk("midrst_cnt",    32'(ErrCnt),    0);
        chk("midrst_cnt_s",  32'(ErrCntS),   0);
        step();
        #2 Rst = 1'b0;
        nz = 0;
        for (int k = 0; k < 12; k++) begin
            Rx = (k == 2) ? 1'b0 : 1'b1;
            step();
            if (ErrPulse != 0) nz++;
        end
        chk("midrst_no_pulse", 32'(nz), 0);

        // Randomized traffic
        injLeft = 0;
        for (int c = 0; c < 3000; c++) begin
            phase = c / 1000;
            if (c % 64 == 0) CheckEn = 5'($urandom);
            if (injLeft == 0 && phase != 1 && $urandom_range(0, 11) == 0) begin
                injLeft = 8;
                if ($urandom_range(0, 3) != 0) fdPlan[c + 7 + FLAG_LAT] = 1'b1;
            end
            if (injLeft > 0) begin
                Rx = (injLeft == 8 || injLeft == 1) ? 1'b0 : 1'b1;
                injLeft--;
            end else begin
                Rx = 1'($urandom_range(0, 1));
            end
            if (phase == 1) Rx_FlagDetect = fdPlan[c] || ($urandom_range(0, 399) == 0);
            else            Rx_FlagDetect = fdPlan[c] || ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) Rx_ValidFrame = ~Rx_ValidFrame;
            Rx_AbortDetect  = ($urandom_range(0, 5) == 0);
            Rx_AbortSignal  = ($urandom_range(0, 3) != 0);
            Rx_EoF          = 1'($urandom_range(0, 1));
            Rx_NewByte      = (phase == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            Rx_Overflow     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) Tx_AbortFrame = ~Tx_AbortFrame;
            Tx_ValidFrame   = 1'($urandom_range(0, 1));
            Tx_AbortedTrans = ($urandom_range(0, 11) == 0);
            ErrClr          = ($urandom_range(0, 49) == 0);
            if (c == 2500) begin
                Rst = 1'b1;
                step(); step();
                #2 Rst = 1'b0;
            end
            step();
        end
        quiet();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_protocol_checker.md
HDLC_PROTOCOL_CHECKER -- requirements
Module: hdlc_protocol_checker

Interface
REQ-001 SHALL have parameter FLAG_LAT, default 2: cycles from the final flag bit on Rx to the required Rx_FlagDetect (range 1..8).
REQ-002 SHALL have parameter MAX_BYTES, default 128: Rx_NewByte count after which Rx_Overflow is required.
REQ-003 SHALL have parameter ABORT_WIN, default 16: maximum cycles from a Tx abort request to Tx_AbortedTrans.
REQ-004 SHALL have parameter CNT_W, default 16: error counter width.
REQ-005 Clk  in  1  single clock; all logic on posedge.
REQ-006 Rst  in  1  asynchronous, active-high reset.
REQ-007 Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_EoF, Rx_NewByte, Rx_Overflow  in  1 each  observed Rx datapath signals.
REQ-008 Tx_AbortFrame, Tx_ValidFrame, Tx_AbortedTrans  in  1 each  observed Tx signals.
REQ-009 CheckEn  in  5  per-check enable; bit index = check ID.
REQ-010 ErrClr  in  1  synchronous clear of ErrSticky and ErrCnt.
REQ-011 ErrPulse  out  5  one-cycle per-check violation strobe.
REQ-012 ErrSticky  out  5  latched per-check violation flags.
REQ-013 ErrCnt  out  CNT_W  saturating total violation count.

Function
REQ-014 Check IDs: 0 FLAG, 1 ABORT_SIG, 2 EOF, 3 OVF, 4 TX_ABORT; a disabled check SHALL never assert its ErrPulse, but its internal tracking SHALL keep running.
REQ-015 FLAG: 7-bit Rx history plus current Rx forms the 8-bit window; window equal to 0,1,1,1,1,1,1,0 (time order) at cycle t SHALL require Rx_FlagDetect=1 at t+FLAG_LAT, else ErrPulse[0] at t+FLAG_LAT.
REQ-016 FLAG: tracking SHALL use a FLAG_LAT-deep pending shift line so overlapping detections (flags back-to-back sharing a 0) are each checked independently.
REQ-017 ABORT_SIG: Rx_AbortDetect&&Rx_ValidFrame at t SHALL require Rx_AbortSignal at t+1, else ErrPulse[1] at t+1.
REQ-018 EOF: Rx_ValidFrame 1->0 between t-1 and t SHALL require Rx_EoF at t+1, else ErrPulse[2] at t+1; no check in the first cycle after reset.
REQ-019 OVF: byte counter (width clog2(MAX_BYTES+1)) SHALL clear on Rx_FlagDetect&&!Rx_ValidFrame and increment on Rx_NewByte, saturating at MAX_BYTES; clear wins if both occur in the same cycle.
REQ-020 OVF: the cycle the counter transitions to MAX_BYTES SHALL arm a check requiring Rx_Overflow on the next cycle, else ErrPulse[3]; a counter sitting at saturation SHALL not re-arm.
REQ-021 TX_ABORT FSM states IDLE, WAIT, DONE: IDLE->WAIT on Tx_AbortFrame&&Tx_ValidFrame (timer loaded with ABORT_WIN); WAIT->DONE on Tx_AbortedTrans; WAIT->IDLE with ErrPulse[4] when the timer reaches 0 without Tx_AbortedTrans; DONE->IDLE when Tx_AbortFrame=0.
REQ-022 Tx_AbortedTrans in the same cycle as timer expiry SHALL count as pass.
REQ-023 ErrPulse SHALL be registered; ErrSticky[i] SHALL set on ErrPulse[i].
REQ-024 ErrCnt SHALL add popcount(ErrPulse) each cycle, saturating at 2^CNT_W-1, never wrapping.
REQ-025 ErrClr with a simultaneous ErrPulse: sticky SHALL end at the new pulse bits and ErrCnt at popcount(ErrPulse).

Reset
REQ-026 Rst=1 SHALL force ErrPulse=0, ErrSticky=0, ErrCnt=0, Rx history=7'b1111111, pending lines=0, byte counter=0, FSM=IDLE, timer=0, immediately and independent of Clk.
REQ-027 Reset mid-operation SHALL discard all pending checks; no ErrPulse SHALL arise from stimulus preceding reset release.

Structure
REQ-028 Package hdlc_chk_pkg SHALL hold NUM_CHECKS=5, check-ID enum, FLAG_PATTERN=8'h7E, and the TX_ABORT FSM state typedef.
REQ-029 Saturating accumulator SHALL be a sub-module hdlc_chk_satcnt (parameters WIDTH, INC_W).

Verification
REQ-030 Rx=0,1x6,0 with Rx_FlagDetect pulsed 2 cycles after the last 0 -> ErrPulse=0; same with pulse at 3 cycles -> ErrPulse[0] one cycle at t+2, ErrCnt=1.
REQ-031 Rx_AbortDetect=1, Rx_ValidFrame=1, Rx_AbortSignal held 0 -> ErrPulse[1] next cycle, ErrSticky=5'b00010.
REQ-032 Flag then 128 Rx_NewByte strobes, Rx_Overflow next cycle -> no error; 200 strobes without Rx_Overflow -> exactly one ErrPulse[3].
REQ-033 Tx_AbortFrame during Tx_ValidFrame, Tx_AbortedTrans at cycle 16 -> pass; at cycle 17 -> ErrPulse[4].
REQ-034 CNT_W=2, five violations -> ErrCnt=3; ErrClr with a same-cycle violation -> ErrCnt=1.
REQ-035 Rst asserted mid-flag (after four 1s) -> all outputs 0 immediately, no ErrPulse after release.
